// File: rtl/usb_stream_pkg.sv
// rtl/usb_stream_pkg.sv - shared stream FSM encodings and width defaults
package usb_stream_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } stream_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] base;

  // clear happens first so an increment in the same cycle counts from zero
  always_comb begin
    base = clr ? '0 : q;
  end

  // count up, sticking at all-ones
  always_ff @(posedge clk) begin
    if (reset_) begin
      q <= '0;
    end else if (inc && (base != '1)) begin
      q <= base + ONE;
    end else begin
      q <= base;
    end
  end

endmodule

// File: rtl/counter_data_check.sv
// rtl/counter_data_check.sv - incrementing-sequence continuity checker for StreamOUT data
module counter_data_check
  import usb_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 32,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              check_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              clear_errors,
  output logic              locked,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count,
  output logic [DATA_W-1:0] err_expected,
  output logic [DATA_W-1:0] err_received
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  stream_state_t     state_q, state_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic              word_hit;
  logic              err_hit;

  // next state, next expected word and per-word classification
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    word_hit   = 1'b0;
    err_hit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (data_valid) begin
          expected_d = data_in + ONE;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (data_valid) begin
          word_hit = 1'b1;
          if (data_in == expected_q) begin
            expected_d = expected_q + ONE;
          end else begin
            err_hit    = 1'b1;
            expected_d = data_in + ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // disabling overrides everything: word ignored, state falls back to idle
    if (!check_en) begin
      state_d    = ST_IDLE;
      expected_d = expected_q;
      word_hit   = 1'b0;
      err_hit    = 1'b0;
    end
  end

  // FSM state and expected-word registers
  always_ff @(posedge clk) begin
    if (reset_) begin
      state_q    <= ST_IDLE;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
    end
  end

  // error pulse, sticky flag and first-error snapshot; a new error beats a clear
  always_ff @(posedge clk) begin
    if (reset_) begin
      err_pulse    <= 1'b0;
      err_sticky   <= 1'b0;
      err_expected <= '0;
      err_received <= '0;
    end else begin
      err_pulse <= err_hit;
      if (err_hit && (!err_sticky || clear_errors)) begin
        err_sticky   <= 1'b1;
        err_expected <= expected_q;
        err_received <= data_in;
      end else if (clear_errors) begin
        err_sticky   <= 1'b0;
        err_expected <= '0;
        err_received <= '0;
      end
    end
  end

  assign locked = (state_q == ST_CHECK);

  sat_counter #(.W(ERR_W)) u_err_count (
    .clk    (clk),
    .reset_ (reset_),
    .clr    (clear_errors),
    .inc    (err_hit),
    .q      (err_count)
  );

  sat_counter #(.W(CNT_W)) u_word_count (
    .clk    (clk),
    .reset_ (reset_),
    .clr    (1'b0),
    .inc    (word_hit),
    .q      (word_count)
  );

endmodule

// File: tb/tb_counter_data_check.sv
// tb/tb_counter_data_check.sv - randomized self-checking bench for counter_data_check
module tb_counter_data_check;

  logic        clk;
  logic        reset_;
  logic        check_en;
  logic [31:0] data_in;
  logic        data_valid;
  logic        clear_errors;

  logic        locked_a, err_pulse_a, err_sticky_a;
  logic [15:0] err_count_a;
  logic [31:0] word_count_a, err_expected_a, err_received_a;

  logic        locked_b, err_pulse_b, err_sticky_b;
  logic [1:0]  err_count_b;
  logic [31:0] word_count_b, err_expected_b, err_received_b;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // reference model: stream rules applied at the word level
  int          m_mode;   // 0 disabled, 1 waiting for seed, 2 checking
  logic [31:0] m_exp;
  longint      m_words;
  int          m_errs;
  logic        m_pulse;
  logic        m_sticky;
  logic [31:0] m_snap_e, m_snap_r;

  counter_data_check #(.DATA_W(32), .CNT_W(32), .ERR_W(16)) dut_a (
    .clk          (clk),
    .reset_       (reset_),
    .check_en     (check_en),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .clear_errors (clear_errors),
    .locked       (locked_a),
    .err_pulse    (err_pulse_a),
    .err_sticky   (err_sticky_a),
    .err_count    (err_count_a),
    .word_count   (word_count_a),
    .err_expected (err_expected_a),
    .err_received (err_received_a)
  );

  counter_data_check #(.DATA_W(32), .CNT_W(32), .ERR_W(2)) dut_b (
    .clk          (clk),
    .reset_       (reset_),
    .check_en     (check_en),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .clear_errors (clear_errors),
    .locked       (locked_b),
    .err_pulse    (err_pulse_b),
    .err_sticky   (err_sticky_b),
    .err_count    (err_count_b),
    .word_count   (word_count_b),
    .err_expected (err_expected_b),
    .err_received (err_received_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input logic vld,
                            input logic clr, input logic [31:0] din);
    if (rst) begin
      m_mode = 0; m_exp = 0; m_words = 0; m_errs = 0;
      m_pulse = 0; m_sticky = 0; m_snap_e = 0; m_snap_r = 0;
      return;
    end
    m_pulse = 0;
    if (clr) begin
      m_errs = 0; m_sticky = 0; m_snap_e = 0; m_snap_r = 0;
    end
    if (!en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (vld) begin
        m_exp  = din + 32'd1;
        m_mode = 2;
      end
    end else if (vld) begin
      m_words++;
      if (din == m_exp) begin
        m_exp = m_exp + 32'd1;
      end else begin
        m_errs++;
        m_pulse = 1;
        if (!m_sticky) begin
          m_sticky = 1; m_snap_e = m_exp; m_snap_r = din;
        end
        m_exp = din + 32'd1;
      end
    end
  endtask

  task automatic compare_all();
    longint wc;
    int ea, eb;
    wc = (m_words > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_words;
    ea = (m_errs > 65535) ? 65535 : m_errs;
    eb = (m_errs > 3) ? 3 : m_errs;
    if (err_pulse_a === 1'b1) pulses++;
    check("a.locked",   locked_a,       m_mode == 2);
    check("a.pulse",    err_pulse_a,    m_pulse);
    check("a.sticky",   err_sticky_a,   m_sticky);
    check("a.errs",     err_count_a,    ea);
    check("a.words",    word_count_a,   wc);
    check("a.snap_exp", err_expected_a, m_snap_e);
    check("a.snap_rcv", err_received_a, m_snap_r);
    check("b.locked",   locked_b,       m_mode == 2);
    check("b.pulse",    err_pulse_b,    m_pulse);
    check("b.sticky",   err_sticky_b,   m_sticky);
    check("b.errs",     err_count_b,    eb);
    check("b.words",    word_count_b,   wc);
    check("b.snap_exp", err_expected_b, m_snap_e);
    check("b.snap_rcv", err_received_b, m_snap_r);
  endtask

  task automatic cycle(input logic rst, input logic en, input logic vld,
                       input logic clr, input logic [31:0] din);
    reset_ = rst; check_en = en; data_valid = vld; clear_errors = clr; data_in = din;
    @(posedge clk);
    model_step(rst, en, vld, clr, din);
    @(negedge clk);
    compare_all();
  endtask

  task automatic feed(input logic [31:0] w);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, w);
  endtask

  task automatic restart();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] din;
    reset_ = 1'b1; check_en = 1'b0; data_in = '0; data_valid = 1'b0; clear_errors = 1'b0;
    @(negedge clk);

    // reset state
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check("rst.words", word_count_a, 0);
    check("rst.locked", locked_a, 0);

    // 1: clean 0..99
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    pulses = 0;
    feed(32'd0);
    check("t1.locked_first", locked_a, 1);
    for (int i = 1; i < 100; i++) feed(i);
    check("t1.words", word_count_a, 99);
    check("t1.errs", err_count_a, 0);
    check("t1.pulses", pulses, 0);

    // 2: wrap is legal
    restart();
    feed(32'hFFFF_FFFD); feed(32'hFFFF_FFFE); feed(32'hFFFF_FFFF); feed(32'h0); feed(32'h1);
    check("t2.words", word_count_a, 4);
    check("t2.errs", err_count_a, 0);

    // 3: single gap
    restart();
    pulses = 0;
    feed(10); feed(11); feed(12); feed(15);
    check("t3.pulse_now", err_pulse_a, 1);
    feed(16);
    check("t3.pulses", pulses, 1);
    check("t3.errs", err_count_a, 1);
    check("t3.snap_e", err_expected_a, 13);
    check("t3.snap_r", err_received_a, 15);
    check("t3.sticky", err_sticky_a, 1);

    // 4: second gap keeps snapshot; clear coincident with a gap
    feed(20);
    check("t4.errs2", err_count_a, 2);
    check("t4.snap_e", err_expected_a, 13);
    check("t4.snap_r", err_received_a, 15);
    feed(21);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'd30);
    check("t4.errs_clr", err_count_a, 1);
    check("t4.snap_e2", err_expected_a, 22);
    check("t4.snap_r2", err_received_a, 30);
    check("t4.sticky2", err_sticky_a, 1);

    // 5: disable mid-stream, then re-seed
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd500);
    check("t5.unlocked", locked_a, 0);
    check("t5.words_held", word_count_a, 7);
    check("t5.errs_held", err_count_a, 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    feed(7); feed(8);
    check("t5.errs_after", err_count_a, 1);
    check("t5.words_after", word_count_a, 8);

    // 6: reset with valid data, then saturation on the narrow counter
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd9);
    check("t6.locked", locked_a, 0);
    check("t6.words", word_count_a, 0);
    check("t6.errs", err_count_a, 0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    feed(0);
    for (int i = 1; i <= 5; i++) feed(i * 5);
    check("t6.sat", err_count_b, 3);
    check("t6.wide", err_count_a, 5);

    // randomized traffic
    restart();
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       din = $urandom;
        1:       din = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: din = m_exp;
      endcase
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 19) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, din);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
